dmem_port: RTL and testbench
============================

// Module: dmem_port
// PURPOSE
//  Data-memory front end directly downstream of the load/store unit. Takes LSU read/write requests,
//  buffers stores in a FIFO store buffer and forwards from it to matching loads. Drains stores to a
//  single req/ack RAM port, with loads prioritised. Returns load data via a one-cycle mem_rvalid pulse.
// PARAMETERS
//  SB_DEPTH  4   store-buffer entries; power of 2, >=2
// PORTS
//  clk          in   1   clock, all state on posedge
//  rst_n        in   1   asynchronous active-low reset
//  mem_ren      in   1   LSU load request
//  mem_raddr    in   64  load byte address
//  mem_rready   out  1   load accepted this cycle if mem_ren=1; = !rd_pend
//  mem_rvalid   out  1   one-cycle pulse, mem_rdata valid
//  mem_rdata    out  64  load data
//  mem_wen      in   1   LSU store request
//  mem_waddr    in   64  store byte address
//  mem_wdata    in   64  store data
//  mem_wready   out  1   store accepted this cycle if mem_wen=1; = (sb_count<SB_DEPTH)
//  ram_req      out  1   RAM transaction request, held until ram_ack
//  ram_we       out  1   1=write, 0=read; stable while ram_req
//  ram_addr     out  64  8-byte-aligned address ([2:0]=0); stable while ram_req
//  ram_wdata    out  64  write data; stable while ram_req
//  ram_ack      in   1   completes the current transaction (any latency >=1 cycle after req)
//  ram_rdata    in   64  read data, valid in the ram_ack cycle
//  sb_empty     out  1   store buffer empty and no RAM write in flight
//  sb_overflow  out  1   sticky: mem_wen seen while mem_wready=0
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0 except mem_rready=1, mem_wready=1, sb_empty=1.
//   rd_pend, SB pointers and count clear. An in-flight RAM transaction is abandoned; ram_req drops immediately.
//  Addressing: word address = addr[63:3]. Forwarding compare and ram_addr use this aligned address only.
//  Store accept: mem_wen&mem_wready -> enqueue {addr,data} at tail. Full blocks enqueue even when a
//   dequeue occurs the same cycle. Pointers are log2(SB_DEPTH) bits and wrap modulo SB_DEPTH.
//  Load accept: mem_ren&mem_rready. Compare against all valid SB entries plus a store accepted
//   the same cycle (treated as youngest).
//   Hit: the youngest matching entry's data is registered -> mem_rvalid=1 next cycle. No RAM access, rd_pend stays 0.
//   Miss: latch aligned address, set rd_pend.
//  FSM states IDLE, RD, WR:
//   IDLE: if rd_pend -> RD (ram_req=1, ram_we=0). Else if SB non-empty -> WR with the head entry
//    (ram_we=1). ram_req asserts the cycle after the decision, from registers.
//   RD: on ram_ack, register ram_rdata. mem_rvalid=1 next cycle and rd_pend clears that cycle -> IDLE.
//   WR: on ram_ack, dequeue the head -> IDLE.
//   ram_ack in IDLE is ignored.
//  Ordering: while rd_pend=1 no new write is started, so a younger store can never reach RAM
//   before an older load. A WR already in flight completes first. The SB may fill; mem_wready then drops.
//  Back-to-back: the earliest next mem_ren accept is the mem_rvalid cycle of the previous load.
//  sb_overflow: set on mem_wen&!mem_wready. Cleared only by reset. The store is dropped.
//  mem_rvalid is never asserted without a prior accepted load. Exactly one pulse per accepted load.
// TESTING
//  1 Reset: rst_n=0 mid-WR -> ram_req=0 same cycle. mem_rready=1, mem_wready=1, sb_empty=1, sb_overflow=0.
//  2 Load miss: ren, raddr=0x108, SB empty; RAM acks 3 cycles after req with 0xDEAD ->
//    ram_addr=0x108, ram_we=0, mem_rvalid=1 with 0xDEAD exactly once.
//  3 Forwarding: store 0x200<-0x11, then 0x200<-0x22, then load 0x204 while RAM is stalled (no ack) ->
//    mem_rvalid next cycle, data 0x22, no ram read issued.
//  4 Same-cycle: wen 0x300<-0x55 and ren 0x300 together with SB empty -> mem_rdata=0x55, no RAM read.
//  5 Full/overflow (SB_DEPTH=4): hold ram_ack=0, issue 5 stores -> 5th sees mem_wready=0 and
//    sb_overflow=1. Then ack 4 writes -> addresses in issue order, sb_empty=1.
//  6 Priority: 2 stores queued, WR in flight, load miss 0x400 -> WR finishes, then RD 0x400,
//    then the remaining store. Pointer wrap: 9 store/drain cycles at depth 4 -> order preserved.

Source files
------------

// File: rtl/dmem_port_if.sv
// LSU-side and RAM-side signal bundle for the data-memory front end.
// The slave modport is the dmem_port view; master is the LSU/RAM environment view.
interface dmem_port_if;
   logic        mem_ren;
   logic [63:0] mem_raddr;
   logic        mem_rready;
   logic        mem_rvalid;
   logic [63:0] mem_rdata;
   logic        mem_wen;
   logic [63:0] mem_waddr;
   logic [63:0] mem_wdata;
   logic        mem_wready;
   logic        ram_req;
   logic        ram_we;
   logic [63:0] ram_addr;
   logic [63:0] ram_wdata;
   logic        ram_ack;
   logic [63:0] ram_rdata;
   logic        sb_empty;
   logic        sb_overflow;

   modport slave (
      input  mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata, ram_ack, ram_rdata,
      output mem_rready, mem_rvalid, mem_rdata, mem_wready,
      output ram_req, ram_we, ram_addr, ram_wdata, sb_empty, sb_overflow
   );

   modport master (
      output mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata, ram_ack, ram_rdata,
      input  mem_rready, mem_rvalid, mem_rdata, mem_wready,
      input  ram_req, ram_we, ram_addr, ram_wdata, sb_empty, sb_overflow
   );
endinterface

// File: rtl/dmem_port.sv
// Data-memory front end: FIFO store buffer with load forwarding, draining to a single
// req/ack RAM port with pending loads taking priority over buffered stores.
module dmem_port #(
   parameter int unsigned SB_DEPTH = 4
) (
   input logic        clk,
   input logic        rst_n,
   dmem_port_if.slave bus
);

   localparam int unsigned PtrW = $clog2(SB_DEPTH);
   localparam logic [PtrW:0] SbFull = SB_DEPTH[PtrW:0];

   typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;

   logic [60:0]     sb_addr_q [SB_DEPTH];
   logic [63:0]     sb_data_q [SB_DEPTH];
   logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
   logic [PtrW:0]   count_q, count_d;
   logic            rd_pend_q, rd_pend_d;
   logic [60:0]     rd_addr_q, rd_addr_d;
   logic            rvalid_q, rvalid_d;
   logic [63:0]     rdata_q, rdata_d;
   state_e          state_q, state_d;
   logic [60:0]     ram_addr_q, ram_addr_d;
   logic [63:0]     ram_wdata_q, ram_wdata_d;
   logic            overflow_q, overflow_d;

   logic        wready;
   logic        st_acc, ld_acc, deq;
   logic [60:0] raddr_w, waddr_w;
   logic        fwd_hit;
   logic [63:0] fwd_data;

   assign raddr_w = bus.mem_raddr[63:3];
   assign waddr_w = bus.mem_waddr[63:3];
   assign wready  = count_q < SbFull;
   assign st_acc  = bus.mem_wen & wready;
   assign ld_acc  = bus.mem_ren & ~rd_pend_q;

   // Scan oldest to youngest so the last match wins; a same-cycle store is youngest of all.
   always_comb begin
      logic [PtrW-1:0] off;
      logic [PtrW-1:0] idx;
      fwd_hit  = 1'b0;
      fwd_data = '0;
      off      = '0;
      idx      = '0;
      for (int unsigned i = 0; i < SB_DEPTH; i++) begin
         off = i[PtrW-1:0];
         idx = head_q + off;
         if (({1'b0, off} < count_q) && (sb_addr_q[idx] == raddr_w)) begin
            fwd_hit  = 1'b1;
            fwd_data = sb_data_q[idx];
         end
      end
      if (st_acc && (waddr_w == raddr_w)) begin
         fwd_hit  = 1'b1;
         fwd_data = bus.mem_wdata;
      end
   end

   always_comb begin
      state_d     = state_q;
      head_d      = head_q;
      tail_d      = tail_q;
      rd_pend_d   = rd_pend_q;
      rd_addr_d   = rd_addr_q;
      rvalid_d    = 1'b0;
      rdata_d     = rdata_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      overflow_d  = overflow_q | (bus.mem_wen & ~wready);
      deq         = 1'b0;

      if (st_acc) begin
         tail_d = tail_q + 1'b1;
      end

      if (ld_acc) begin
         if (fwd_hit) begin
            rvalid_d = 1'b1;
            rdata_d  = fwd_data;
         end else begin
            rd_pend_d = 1'b1;
            rd_addr_d = raddr_w;
         end
      end

      unique case (state_q)
         StIdle: begin
            // A pending load blocks new writes so younger stores cannot overtake it.
            if (rd_pend_q) begin
               state_d    = StRd;
               ram_addr_d = rd_addr_q;
            end else if (count_q != '0) begin
               state_d     = StWr;
               ram_addr_d  = sb_addr_q[head_q];
               ram_wdata_d = sb_data_q[head_q];
            end
         end
         StRd: begin
            if (bus.ram_ack) begin
               rvalid_d  = 1'b1;
               rdata_d   = bus.ram_rdata;
               rd_pend_d = 1'b0;
               state_d   = StIdle;
            end
         end
         StWr: begin
            if (bus.ram_ack) begin
               deq     = 1'b1;
               head_d  = head_q + 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      count_d = count_q + {{PtrW{1'b0}}, st_acc} - {{PtrW{1'b0}}, deq};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         rd_pend_q   <= 1'b0;
         rd_addr_q   <= '0;
         rvalid_q    <= 1'b0;
         rdata_q     <= '0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         rd_pend_q   <= rd_pend_d;
         rd_addr_q   <= rd_addr_d;
         rvalid_q    <= rvalid_d;
         rdata_q     <= rdata_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         overflow_q  <= overflow_d;
      end
   end

   // Entry contents need no reset: validity is tracked by head/count alone.
   always_ff @(posedge clk) begin
      if (st_acc) begin
         sb_addr_q[tail_q] <= waddr_w;
         sb_data_q[tail_q] <= bus.mem_wdata;
      end
   end

   assign bus.mem_rready  = ~rd_pend_q;
   assign bus.mem_wready  = wready;
   assign bus.mem_rvalid  = rvalid_q;
   assign bus.mem_rdata   = rdata_q;
   assign bus.ram_req     = state_q != StIdle;
   assign bus.ram_we      = state_q == StWr;
   assign bus.ram_addr    = {ram_addr_q, 3'b000};
   assign bus.ram_wdata   = ram_wdata_q;
   assign bus.sb_empty    = (count_q == '0) && (state_q != StWr);
   assign bus.sb_overflow = overflow_q;

endmodule

// File: tb/tb_dmem_port.sv
// Scoreboard bench for dmem_port: expected load data and RAM transactions are queued at
// stimulus time and checked by a separate monitor against a simple ack-latency RAM model.
module tb_dmem_port;

   typedef struct {
      logic        we;
      logic [63:0] addr;
      logic [63:0] wdata;
   } ram_txn_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   logic [63:0] exp_rd_q [$];
   ram_txn_t    exp_ram_q [$];
   logic [63:0] mem [logic [63:0]];
   bit          ram_stall = 1'b0;
   int          ack_lat = 3;
   bit          req_seen = 1'b0;

   dmem_port_if bus ();

   dmem_port #(.SB_DEPTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got=%h exp=%h", name, act, exp);
      end
   endtask

   // RAM model: acks ack_lat cycles after ram_req is first seen, unless stalled.
   initial begin
      int age;
      age = 0;
      bus.ram_ack   = 1'b0;
      bus.ram_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.ram_ack = 1'b0;
         if (rst_n && bus.ram_req && !ram_stall) begin
            if (age >= ack_lat) begin
               bus.ram_ack = 1'b1;
               if (bus.ram_we) mem[bus.ram_addr] = bus.ram_wdata;
               else bus.ram_rdata = mem[bus.ram_addr];
               age = 0;
            end else begin
               age++;
            end
         end else begin
            age = 0;
         end
      end
   end

   // Monitor: pops expectations whenever the DUT presents load data or a new RAM request.
   initial begin
      logic [63:0] e;
      ram_txn_t    t;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            req_seen = 1'b0;
         end else begin
            if (bus.mem_rvalid) begin
               if (exp_rd_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL rvalid_unexpected: got=%h exp=none", bus.mem_rdata);
               end else begin
                  e = exp_rd_q.pop_front();
                  chk("load_data", bus.mem_rdata, e);
               end
            end
            if (bus.ram_req && !req_seen) begin
               req_seen = 1'b1;
               if (exp_ram_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL ram_unexpected: got we=%b addr=%h exp=none", bus.ram_we,
                           bus.ram_addr);
               end else begin
                  t = exp_ram_q.pop_front();
                  chk("ram_we", {63'd0, bus.ram_we}, {63'd0, t.we});
                  chk("ram_addr", bus.ram_addr, t.addr);
                  if (t.we) chk("ram_wdata", bus.ram_wdata, t.wdata);
               end
            end
            if (bus.ram_ack) req_seen = 1'b0;
         end
      end
   end

   task automatic reset_and_check(input string name);
      rst_n = 1'b0;
      #1;
      chk({name, "_ram_req"}, {63'd0, bus.ram_req}, 64'd0);
      chk({name, "_rready"}, {63'd0, bus.mem_rready}, 64'd1);
      chk({name, "_wready"}, {63'd0, bus.mem_wready}, 64'd1);
      chk({name, "_sb_empty"}, {63'd0, bus.sb_empty}, 64'd1);
      chk({name, "_overflow"}, {63'd0, bus.sb_overflow}, 64'd0);
      chk({name, "_rvalid"}, {63'd0, bus.mem_rvalid}, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic push_ram(input logic we, input logic [63:0] addr, input logic [63:0] wdata);
      ram_txn_t t;
      t.we    = we;
      t.addr  = addr;
      t.wdata = wdata;
      exp_ram_q.push_back(t);
   endtask

   // Tasks start and end 1 time unit after a rising edge.
   task automatic store(input logic [63:0] addr, input logic [63:0] data, input bit no_wait);
      int n = 0;
      while (!no_wait && !bus.mem_wready && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 200) chk("store_wready_timeout", 64'd0, 64'd1);
      bus.mem_wen   = 1'b1;
      bus.mem_waddr = addr;
      bus.mem_wdata = data;
      @(posedge clk);
      #1;
      bus.mem_wen = 1'b0;
   endtask

   task automatic load(input logic [63:0] addr, input logic [63:0] exp, input bit chk_next);
      int n = 0;
      while (!bus.mem_rready && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 200) chk("load_rready_timeout", 64'd0, 64'd1);
      exp_rd_q.push_back(exp);
      bus.mem_ren   = 1'b1;
      bus.mem_raddr = addr;
      @(posedge clk);
      #1;
      bus.mem_ren = 1'b0;
      if (chk_next) chk("load_hit_next_cycle", {63'd0, bus.mem_rvalid}, 64'd1);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((exp_rd_q.size() != 0 || exp_ram_q.size() != 0 || !bus.sb_empty || bus.ram_req)
             && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      repeat (3) @(posedge clk);
      #1;
      chk({name, "_loads_done"}, 64'(exp_rd_q.size()), 64'd0);
      chk({name, "_ram_done"}, 64'(exp_ram_q.size()), 64'd0);
      chk({name, "_sb_empty"}, {63'd0, bus.sb_empty}, 64'd1);
   endtask

   initial begin
      int n;
      bus.mem_ren   = 1'b0;
      bus.mem_raddr = '0;
      bus.mem_wen   = 1'b0;
      bus.mem_waddr = '0;
      bus.mem_wdata = '0;
      mem[64'h108] = 64'hDEAD;
      mem[64'h400] = 64'h4444;

      reset_and_check("reset_init");

      // Reset while a write is held by the RAM: request must drop asynchronously.
      ram_stall = 1'b1;
      push_ram(1'b1, 64'h500, 64'h1);
      store(64'h500, 64'h1, 1'b0);
      n = 0;
      while (!bus.ram_req && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("midwr_req_seen", {63'd0, bus.ram_req}, 64'd1);
      @(negedge clk);
      #1;
      reset_and_check("reset_midwr");
      ram_stall = 1'b0;
      wait_idle("after_reset");

      // Load miss with a 3-cycle RAM.
      ack_lat = 3;
      push_ram(1'b0, 64'h108, 64'h0);
      load(64'h10C, 64'hDEAD, 1'b0);
      wait_idle("load_miss");

      // Forwarding from the youngest of two matching stores while RAM is stalled.
      ram_stall = 1'b1;
      push_ram(1'b1, 64'h200, 64'h11);
      push_ram(1'b1, 64'h200, 64'h22);
      store(64'h200, 64'h11, 1'b0);
      store(64'h200, 64'h22, 1'b0);
      load(64'h204, 64'h22, 1'b1);
      ram_stall = 1'b0;
      wait_idle("forward");

      // Same-cycle store and load to the same word with an empty buffer.
      push_ram(1'b1, 64'h300, 64'h55);
      exp_rd_q.push_back(64'h55);
      bus.mem_wen   = 1'b1;
      bus.mem_waddr = 64'h300;
      bus.mem_wdata = 64'h55;
      bus.mem_ren   = 1'b1;
      bus.mem_raddr = 64'h300;
      @(posedge clk);
      #1;
      bus.mem_wen = 1'b0;
      bus.mem_ren = 1'b0;
      chk("same_cycle_rvalid", {63'd0, bus.mem_rvalid}, 64'd1);
      wait_idle("same_cycle");

      // Fill the buffer, overflow on the fifth store, then drain in issue order.
      ram_stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push_ram(1'b1, 64'h600 + 64'(8 * i), 64'(i + 1));
         store(64'h600 + 64'(8 * i), 64'(i + 1), 1'b0);
      end
      chk("full_wready", {63'd0, bus.mem_wready}, 64'd0);
      chk("full_no_overflow_yet", {63'd0, bus.sb_overflow}, 64'd0);
      store(64'h620, 64'h5, 1'b1);
      chk("overflow_set", {63'd0, bus.sb_overflow}, 64'd1);
      ram_stall = 1'b0;
      wait_idle("full_drain");
      chk("overflow_sticky", {63'd0, bus.sb_overflow}, 64'd1);
      reset_and_check("reset_overflow");

      // An in-flight write finishes, then the pending load, then the remaining store.
      ram_stall = 1'b1;
      push_ram(1'b1, 64'h700, 64'hA);
      push_ram(1'b0, 64'h400, 64'h0);
      push_ram(1'b1, 64'h708, 64'hB);
      store(64'h700, 64'hA, 1'b0);
      store(64'h708, 64'hB, 1'b0);
      load(64'h400, 64'h4444, 1'b0);
      ram_stall = 1'b0;
      wait_idle("priority");

      // Nine store/drain rounds wrap the depth-4 pointers twice.
      ack_lat = 1;
      for (int i = 0; i < 9; i++) begin
         push_ram(1'b1, 64'h800 + 64'(8 * i), 64'h100 + 64'(i));
         store(64'h800 + 64'(8 * i), 64'h100 + 64'(i), 1'b0);
      end
      wait_idle("wrap");
      push_ram(1'b0, 64'h840, 64'h0);
      load(64'h840, 64'h108, 1'b0);
      wait_idle("wrap_readback");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog: got=timeout exp=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
